mlp_seq_engine: RTL and testbench
=================================

Name: mlp_seq_engine

Overview:
Parametrised, sequential successor to the diabetes-detector MLP datapath. It runs one MAC per clock through three phases:
- input normalisation,
- a hidden layer of N_HID neurons with clipped ReLU,
- a single output neuron with 4-level classification.

Scales, weights and biases live in a runtime-loadable memory instead of being hard-coded. The block sits between the keypad/entry FSM, which writes integer inputs and pulses start, and the 7-segment display, which shows the class result.

Parameters:
N_IN, 8, number of integer inputs
N_HID, 8, hidden neurons
W, 32, signed fixed-point word width
FRAC, 16, fractional bits (Q(W-FRAC).FRAC)
ADDR_W, 7, weight-memory address width; must satisfy 2^ADDR_W >= DEPTH = N_IN + N_HID*(N_IN+1) + N_HID + 1 (89 at defaults)
THR0, 32'h0000_6666, class-1 threshold (0.4)
THR1, 32'h0000_8000, class-2 threshold (0.5)
THR2, 32'h0000_9999, class-3 threshold (0.6)

Ports:
ADC_CLK_10  in  1  sole clock, rising edge
rst  in  1  synchronous, active-high reset
in_we  in  1  write strobe for the input register file
in_idx  in  clog2(N_IN)  input index
in_data  in  W  unsigned integer input value (not fixed-point)
wt_we  in  1  weight-memory write strobe
wt_addr  in  ADDR_W  weight-memory address
wt_data  in  W  signed Q value
start  in  1  single-cycle request to run inference
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when results update
y  out  W  signed Q output-neuron value
class_o  out  2  0..3 classification
sat  out  1  y was saturated on the last run

Behaviour:
- Reset values:
  - busy=0, done=0, y=0, class_o=0, sat=0, FSM=IDLE.
  - Input registers cleared to 0.
  - Weight memory is NOT cleared.
- Weight memory map:
  - 0..N_IN-1: input scale s[i].
  - Hidden weights: N_IN + j*(N_IN+1) + i holds w[i][j]; i=N_IN is the bias of neuron j.
  - Output weights: N_IN + N_HID*(N_IN+1) + j holds v[j]; j=N_HID is the output bias.
  - Writes to addresses >= DEPTH are ignored.
- Gating while busy: in_we and wt_we are honoured only in IDLE. start is accepted only in IDLE; while busy it is ignored and nothing is queued.
- Same-edge start and write in IDLE: the write commits and start is accepted on that edge. The write is visible to the run.
- FSM: IDLE -> NORM (N_IN cycles) -> HID (N_HID*(N_IN+1) cycles) -> OUT (N_HID+1 cycles) -> DONE (1 cycle) -> IDLE.
- Latency: start sampled on edge k gives done=1 in the cycle after edge k+DEPTH, i.e. 90 cycles at defaults.
- NORM: x[i] = (in[i] * s[i]), with in[i] zero-extended to 2W signed. The 2W product is arithmetically shifted right by FRAC and truncated to W bits.
- HID, per neuron j:
  - Accumulator is signed W+8 bits, cleared at neuron start.
  - Add trunc((x[i]*w[i][j]) >>> FRAC) for each i, then add the bias unscaled.
  - Activation: h[j] = 0 if acc < 0; h[j] = 1.0 (1<<FRAC) if acc > 1.0; else acc.
- OUT: same MAC over h[j]*v[j] plus bias v[N_HID].
  - Result saturates to [-2^(W-1), 2^(W-1)-1]; sat=1 if clamped.
- Classification (signed compare, strict greater-than): class_o = 3 if y>THR2, 2 if y>THR1, 1 if y>THR0, else 0.
- y, class_o and sat update on the same edge that raises done. They hold until the next done or reset.
- Reset mid-run: the FSM returns to IDLE on that edge, with no done and outputs set to reset values.

Test Plan:
1. Reset: assert rst 2 cycles -> busy=0, done=0, y=0, class_o=0, sat=0; start accepted on the first IDLE cycle afterwards.
2. Bias only: all weights 0, v bias (addr 88) = 0x0000_8000, start -> done exactly 90 cycles later, y=0x0000_8000, class_o=1 (strict compare against THR1), sat=0.
3. Clip high: s[0]=0x0001_0000, in[0]=1, w[0][0]=0x0002_0000, v[0]=0x0000_B333, rest 0 -> h[0]=1.0, y=0x0000_B333, class_o=3.
4. Clip low: as scenario 3 but w[0][0]=-0x0002_0000, v bias=0x0000_6000 -> h[0]=0, y=0x0000_6000, class_o=0.
5. Saturation: all hidden biases 1.0, all v=0x7FFF_FFFF -> y=0x7FFF_FFFF, sat=1, class_o=3.
6. Protocol:
   - start again at cycle 10 of a run -> exactly one done.
   - wt_we at cycle 20 -> memory unchanged.
   - rst at cycle 40 of a new run -> no done, busy=0 next cycle, weights retained (rerun gives the prior y).

Source files
------------

// File: rtl/mlp_seq_engine.sv
// mlp_seq_engine: sequential MLP inference engine that performs one MAC per clock.
// The phases are input normalisation, a hidden layer with clipped ReLU, and one
// output neuron with 4-level classification. Scales, weights and biases are held
// in a runtime-writable memory. One address counter walks that memory linearly
// across all three phases.
module mlp_seq_engine #(
    parameter int N_IN   = 8,
    parameter int N_HID  = 8,
    parameter int W      = 32,
    parameter int FRAC   = 16,
    parameter int ADDR_W = 7,
    parameter logic signed [W-1:0] THR0 = W'(32'h0000_6666),
    parameter logic signed [W-1:0] THR1 = W'(32'h0000_8000),
    parameter logic signed [W-1:0] THR2 = W'(32'h0000_9999)
) (
    input  logic                      ADC_CLK_10,
    input  logic                      rst,
    input  logic                      in_we,
    input  logic [$clog2(N_IN)-1:0]   in_idx,
    input  logic [W-1:0]              in_data,
    input  logic                      wt_we,
    input  logic [ADDR_W-1:0]         wt_addr,
    input  logic signed [W-1:0]       wt_data,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic signed [W-1:0]       y,
    output logic [1:0]                class_o,
    output logic                      sat
);

    localparam int DEPTH = N_IN + N_HID * (N_IN + 1) + N_HID + 1;
    localparam int AW    = W + 8;
    localparam int IW    = $clog2(N_IN);
    localparam int HW    = $clog2(N_HID);
    localparam int CW    = $clog2(N_IN + 1);
    localparam int JW    = $clog2(N_HID + 1);

    localparam logic [CW-1:0] I_NORM_LAST = CW'(N_IN - 1);
    localparam logic [CW-1:0] I_BIAS      = CW'(N_IN);
    localparam logic [JW-1:0] J_HID_LAST  = JW'(N_HID - 1);
    localparam logic [JW-1:0] J_BIAS      = JW'(N_HID);

    localparam logic signed [AW-1:0] ONE_Q = AW'(64'd1 << FRAC);
    localparam logic signed [AW-1:0] Y_MAX = AW'((64'd1 << (W - 1)) - 64'd1);
    localparam logic signed [AW-1:0] Y_MIN = ~Y_MAX;

    typedef enum logic [2:0] {S_IDLE, S_NORM, S_HID, S_OUT, S_DONE} state_t;

    state_t state, state_d;

    logic [W-1:0]        in_reg [N_IN];
    logic signed [W-1:0] mem    [DEPTH];
    logic signed [W-1:0] x_reg  [N_IN];
    logic signed [W-1:0] h_reg  [N_HID];
    logic signed [AW-1:0] acc;

    logic [ADDR_W-1:0] addr;
    logic [CW-1:0]     i_cnt;
    logic [JW-1:0]     j_cnt;

    logic signed [W-1:0]   wt_rd;
    logic signed [2*W-1:0] op_a;
    logic signed [2*W-1:0] op_b;
    logic signed [W-1:0]   prod_q;
    logic signed [AW-1:0]  acc_base;
    logic signed [AW-1:0]  acc_next;
    logic                  is_bias;
    logic                  is_first;

    // Q-format product: full 2W multiply, arithmetic shift by FRAC, keep low W bits
    function automatic logic signed [W-1:0] mul_q(input logic signed [2*W-1:0] a,
                                                  input logic signed [2*W-1:0] b);
        logic signed [2*W-1:0] p;
        p = (a * b) >>> FRAC;
        return p[W-1:0];
    endfunction

    // Clipped ReLU: negative values go to 0, values above 1.0 go to 1.0
    function automatic logic signed [W-1:0] clip_relu(input logic signed [AW-1:0] a);
        if (a[AW-1])
            return '0;
        else if (a > ONE_Q)
            return ONE_Q[W-1:0];
        else
            return a[W-1:0];
    endfunction

    // Saturate the wide accumulator to the signed W-bit range
    function automatic logic signed [W-1:0] sat_y(input logic signed [AW-1:0] a);
        if (a > Y_MAX)
            return Y_MAX[W-1:0];
        else if (a < Y_MIN)
            return Y_MIN[W-1:0];
        else
            return a[W-1:0];
    endfunction

    // Reports whether sat_y had to clamp its argument
    function automatic logic ovf(input logic signed [AW-1:0] a);
        return (a > Y_MAX) || (a < Y_MIN);
    endfunction

    // Four-level class using strict signed greater-than comparisons
    function automatic logic [1:0] classify(input logic signed [W-1:0] v);
        if (v > THR2)
            return 2'd3;
        else if (v > THR1)
            return 2'd2;
        else if (v > THR0)
            return 2'd1;
        else
            return 2'd0;
    endfunction

    assign busy = (state != S_IDLE);

    // MAC datapath: operand selection, Q multiply and accumulate for the current phase
    always_comb begin
        wt_rd    = mem[addr];
        op_b     = {{W{wt_rd[W-1]}}, wt_rd};
        op_a     = '0;
        is_bias  = 1'b0;
        is_first = 1'b0;
        case (state)
            // Integer input is lifted to Q format so the FRAC shift leaves in*s
            S_NORM: op_a = {{W{1'b0}}, in_reg[i_cnt[IW-1:0]]} << FRAC;
            S_HID: begin
                op_a     = {{W{x_reg[i_cnt[IW-1:0]][W-1]}}, x_reg[i_cnt[IW-1:0]]};
                is_bias  = (i_cnt == I_BIAS);
                is_first = (i_cnt == '0);
            end
            S_OUT: begin
                op_a     = {{W{h_reg[j_cnt[HW-1:0]][W-1]}}, h_reg[j_cnt[HW-1:0]]};
                is_bias  = (j_cnt == J_BIAS);
                is_first = (j_cnt == '0);
            end
            default: op_a = '0;
        endcase
        prod_q   = mul_q(op_a, op_b);
        acc_base = is_first ? '0 : acc;
        acc_next = acc_base + (is_bias ? {{(AW-W){wt_rd[W-1]}}, wt_rd}
                                       : {{(AW-W){prod_q[W-1]}}, prod_q});
    end

    // Next-state logic for the phase sequencer
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (start) state_d = S_NORM;
            S_NORM: if (i_cnt == I_NORM_LAST) state_d = S_HID;
            S_HID:  if (i_cnt == I_BIAS && j_cnt == J_HID_LAST) state_d = S_OUT;
            S_OUT:  if (j_cnt == J_BIAS) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge ADC_CLK_10) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    // Control: counters, input register file, result registers and the done pulse
    always_ff @(posedge ADC_CLK_10) begin
        if (rst) begin
            addr    <= '0;
            i_cnt   <= '0;
            j_cnt   <= '0;
            done    <= 1'b0;
            y       <= '0;
            class_o <= 2'd0;
            sat     <= 1'b0;
            for (int k = 0; k < N_IN; k++)
                in_reg[k] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    addr  <= '0;
                    i_cnt <= '0;
                    j_cnt <= '0;
                    if (in_we && int'(in_idx) < N_IN)
                        in_reg[in_idx] <= in_data;
                end
                S_NORM: begin
                    addr  <= addr + 1'b1;
                    i_cnt <= (i_cnt == I_NORM_LAST) ? '0 : i_cnt + 1'b1;
                end
                S_HID: begin
                    addr <= addr + 1'b1;
                    if (i_cnt == I_BIAS) begin
                        i_cnt <= '0;
                        j_cnt <= (j_cnt == J_HID_LAST) ? '0 : j_cnt + 1'b1;
                    end else begin
                        i_cnt <= i_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    addr  <= addr + 1'b1;
                    j_cnt <= j_cnt + 1'b1;
                    if (j_cnt == J_BIAS) begin
                        done    <= 1'b1;
                        y       <= sat_y(acc_next);
                        sat     <= ovf(acc_next);
                        class_o <= classify(sat_y(acc_next));
                    end
                end
                default: ;
            endcase
        end
    end

    // Data storage: weight memory writes (IDLE only), normalised inputs, hidden outputs, accumulator
    always_ff @(posedge ADC_CLK_10) begin
        if (state == S_IDLE && wt_we && int'(wt_addr) < DEPTH)
            mem[wt_addr] <= wt_data;
        if (state == S_NORM)
            x_reg[i_cnt[IW-1:0]] <= prod_q;
        if (state == S_HID || state == S_OUT)
            acc <= acc_next;
        if (state == S_HID && is_bias)
            h_reg[j_cnt[HW-1:0]] <= clip_relu(acc_next);
    end

endmodule

// File: tb/tb_mlp_seq_engine.sv
// Testbench for mlp_seq_engine. A scoreboard queue holds the expected results of
// each run and is popped whenever done is observed.
module tb_mlp_seq_engine;

    typedef struct packed {
        logic [31:0] y;
        logic [1:0]  c;
        logic        s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_we = 1'b0;
    logic [2:0]  in_idx = '0;
    logic [31:0] in_data = '0;
    logic        wt_we = 1'b0;
    logic [6:0]  wt_addr = '0;
    logic [31:0] wt_data = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] y;
    logic [1:0]  class_o;
    logic        sat;

    int total = 0;
    int bad = 0;
    int dcount = 0;

    exp_t        sb[$];
    int          tmem[89];
    logic [31:0] tin[8];

    mlp_seq_engine dut (
        .ADC_CLK_10(clk),
        .rst(rst),
        .in_we(in_we),
        .in_idx(in_idx),
        .in_data(in_data),
        .wt_we(wt_we),
        .wt_addr(wt_addr),
        .wt_data(wt_data),
        .start(start),
        .busy(busy),
        .done(done),
        .y(y),
        .class_o(class_o),
        .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every done must match the oldest pending expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            dcount++;
            if (sb.size() == 0) begin
                chk("spurious_done", {63'd0, done}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("y", {32'd0, y}, {32'd0, e.y});
                chk("class", {62'd0, class_o}, {62'd0, e.c});
                chk("sat", {63'd0, sat}, {63'd0, e.s});
            end
        end
    end

    task automatic wt(input int a, input int d);
        @(negedge clk);
        wt_we = 1'b1; wt_addr = 7'(a); wt_data = d;
        @(negedge clk);
        wt_we = 1'b0;
        if (a < 89) tmem[a] = d;
    endtask

    task automatic inp(input int i, input logic [31:0] d);
        @(negedge clk);
        in_we = 1'b1; in_idx = 3'(i); in_data = d;
        @(negedge clk);
        in_we = 1'b0;
        tin[i] = d;
    endtask

    task automatic zero_all();
        for (int a = 0; a < 89; a++) wt(a, 0);
        for (int i = 0; i < 8; i++) inp(i, 32'd0);
    endtask

    function automatic exp_t mk(input logic [31:0] ey, input logic [1:0] ec, input logic es);
        exp_t e;
        e.y = ey; e.c = ec; e.s = es;
        return e;
    endfunction

    // Reference model written straight from the layer equations
    function automatic exp_t model();
        int     xv[8];
        int     hv[8];
        longint acc, p;
        int     yi;
        exp_t   e;
        for (int i = 0; i < 8; i++) begin
            p = (longint'({32'd0, tin[i]}) <<< 16) * longint'(tmem[i]);
            xv[i] = int'(p >>> 16);
        end
        for (int j = 0; j < 8; j++) begin
            acc = 0;
            for (int i = 0; i < 8; i++) begin
                p = longint'(xv[i]) * longint'(tmem[8 + j*9 + i]);
                acc += longint'(int'(p >>> 16));
            end
            acc += longint'(tmem[8 + j*9 + 8]);
            if (acc < 0) hv[j] = 0;
            else if (acc > 65536) hv[j] = 65536;
            else hv[j] = int'(acc);
        end
        acc = 0;
        for (int j = 0; j < 8; j++) begin
            p = longint'(hv[j]) * longint'(tmem[80 + j]);
            acc += longint'(int'(p >>> 16));
        end
        acc += longint'(tmem[88]);
        e.s = 1'b0;
        if (acc > 64'sd2147483647) begin
            e.y = 32'h7FFF_FFFF; e.s = 1'b1;
        end else if (acc < -64'sd2147483648) begin
            e.y = 32'h8000_0000; e.s = 1'b1;
        end else begin
            e.y = acc[31:0];
        end
        yi = int'(e.y);
        if (yi > 32'sh9999) e.c = 2'd3;
        else if (yi > 32'sh8000) e.c = 2'd2;
        else if (yi > 32'sh6666) e.c = 2'd1;
        else e.c = 2'd0;
        return e;
    endfunction

    // One inference: optional weight write on the same edge as start, then latency check
    task automatic do_run(input string nm, input exp_t e, input bit wr, input int wa, input int wd);
        int lat;
        bit seen;
        sb.push_back(e);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        if (wr) begin
            wt_we = 1'b1; wt_addr = 7'(wa); wt_data = wd;
            tmem[wa] = wd;
        end
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                wt_we = 1'b0;
                chk({nm, "_busy"}, {63'd0, busy}, 64'd1);
            end
            if (done === 1'b1) seen = 1'b1;
        end
        chk({nm, "_latency"}, 64'(lat), 64'd90);
        @(negedge clk);
        chk({nm, "_done_pulse"}, {63'd0, done}, 64'd0);
        chk({nm, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    function automatic int rs(input int r);
        return int'($urandom_range(0, 2*r)) - r;
    endfunction

    initial begin
        int d0;
        int first_lat;

        for (int a = 0; a < 89; a++) tmem[a] = 0;
        for (int i = 0; i < 8; i++) tin[i] = '0;

        // Reset values
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_y", {32'd0, y}, 64'd0);
        chk("rst_class", {62'd0, class_o}, 64'd0);
        chk("rst_sat", {63'd0, sat}, 64'd0);
        rst = 1'b0;

        // Bias only, started on the first cycle after a 2-cycle reset (weights survive reset)
        zero_all();
        wt(88, 32'h0000_8000);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        do_run("bias", mk(32'h0000_8000, 2'd1, 1'b0), 1'b0, 0, 0);
        for (int i = 0; i < 8; i++) tin[i] = '0;

        // Clip high
        zero_all();
        wt(0, 32'h0001_0000);
        inp(0, 32'd1);
        wt(8, 32'h0002_0000);
        wt(80, 32'h0000_B333);
        do_run("cliphi", mk(32'h0000_B333, 2'd3, 1'b0), 1'b0, 0, 0);

        // Clip low, with the output bias written on the same edge as start
        wt(8, -32'sh0002_0000);
        do_run("cliplo", mk(32'h0000_6000, 2'd0, 1'b0), 1'b1, 88, 32'h0000_6000);

        // Positive saturation
        zero_all();
        for (int j = 0; j < 8; j++) wt(16 + 9*j, 32'h0001_0000);
        for (int j = 0; j < 9; j++) wt(80 + j, 32'h7FFF_FFFF);
        do_run("satpos", mk(32'h7FFF_FFFF, 2'd3, 1'b1), 1'b0, 0, 0);

        // Negative saturation
        for (int j = 0; j < 9; j++) wt(80 + j, 32'h8000_0000);
        do_run("satneg", mk(32'h8000_0000, 2'd0, 1'b1), 1'b0, 0, 0);

        // Random weights and inputs checked against the model
        for (int r = 0; r < 2; r++) begin
            for (int a = 0; a < 8; a++) wt(a, rs(32'h2_0000));
            for (int j = 0; j < 8; j++) begin
                for (int i = 0; i < 8; i++) wt(8 + 9*j + i, rs(32'h1_0000));
                wt(16 + 9*j, rs(32'h8000));
            end
            for (int j = 0; j < 8; j++) wt(80 + j, rs(32'h1_0000));
            wt(88, rs(32'h8000));
            for (int i = 0; i < 8; i++) inp(i, 32'($urandom_range(0, 15)));
            do_run("rand", model(), 1'b0, 0, 0);
        end

        // Protocol: repeated start and weight write while busy are ignored
        zero_all();
        wt(88, 32'h0000_8000);
        sb.push_back(mk(32'h0000_8000, 2'd1, 1'b0));
        d0 = dcount;
        first_lat = 0;
        @(negedge clk);
        start = 1'b1;
        for (int lat = 1; lat <= 250; lat++) begin
            @(negedge clk);
            start = 1'b0;
            wt_we = 1'b0;
            if (lat == 10) start = 1'b1;
            if (lat == 20) begin
                wt_we = 1'b1; wt_addr = 7'd88; wt_data = 32'h7000_0000;
            end
            if (done === 1'b1 && first_lat == 0) first_lat = lat;
        end
        chk("busy_start_one_done", 64'(dcount - d0), 64'd1);
        chk("busy_start_latency", 64'(first_lat), 64'd90);

        // Protocol: reset mid-run aborts without done and keeps the weights
        d0 = dcount;
        @(negedge clk);
        start = 1'b1;
        for (int lat = 1; lat <= 40; lat++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tin[i] = '0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_y", {32'd0, y}, 64'd0);
        chk("midrst_class", {62'd0, class_o}, 64'd0);
        repeat (150) @(negedge clk);
        chk("midrst_no_done", 64'(dcount - d0), 64'd0);
        do_run("rerun", mk(32'h0000_8000, 2'd1, 1'b0), 1'b0, 0, 0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
